tff_chain_n: RTL and testbench
==============================

Name: tff_chain_n

Overview:
- Parametrised chain of STAGES T flip-flops, the next generation of the two-stage serial T-flop block.
- Supports two toggle modes: cascade (stage i toggles while stage i-1 is high) and synchronous binary count (stage i toggles when all lower stages are high).
- Adds hold, parallel load, synchronous clear, a terminal-count pulse and a last-stage rising-edge pulse.
- Used as a configurable divider / event counter in the basic-logic library.

Parameters:
- STAGES, 4, number of T stages; legal range 1..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data  input  1  toggle request for stage 0 (cascade mode) or count enable (count mode).
- mode  input  2  00 cascade, 01 count, 10 hold, 11 load.
- clr  input  1  synchronous clear.
- load_val  input  STAGES  parallel load value, used in mode 11.
- q  output  STAGES  stage outputs; q[0] is the first stage.
- q_last  output  1  equals q[STAGES-1] (combinational alias).
- tc  output  1  terminal-count pulse.
- q_rise  output  1  single-cycle pulse after q[STAGES-1] goes 0->1.

Behaviour:
- Reset: rst=1 immediately forces q=0, tc=0, q_rise=0, and the internal q_last delay register to 0, with no clock needed. Reset may assert mid-operation. After rst deasserts, the first rising edge operates normally.
- Priority at each rising edge: clr > mode.
  - clr=1: q<=0, tc<=0. q_rise is still computed from the old and new q[STAGES-1].
- mode 00, cascade:
  - q[0] toggles if data=1.
  - q[i] (i>=1) toggles if the pre-edge q[i-1]=1. This is level-sensitive, so a stage keeps toggling every cycle while its predecessor is high.
  - No ripple: all stages sample pre-edge values.
- mode 01, count:
  - If data=1: q <= q+1 modulo 2^STAGES, i.e. q[i] toggles when data & (&q[i-1:0]).
  - If data=0: q holds.
- mode 10, hold: q unchanged, data ignored.
- mode 11, load: q <= load_val.
- tc (registered):
  - tc <= (mode==01) & data & (&q) & ~clr.
  - So tc is high for exactly one cycle, the cycle in which q shows 0 after a wrap.
  - In all other modes tc <= 0.
- q_rise (registered):
  - q_rise <= new q[STAGES-1] & ~old q[STAGES-1], evaluated each edge.
  - High for one cycle after any 0->1 change, including one caused by load.
- Mode changes take effect on the next edge. No state is reset on a mode change.
- STAGES=1: cascade and count are identical (q[0] toggles on data). tc fires when q goes 1->0 in count mode.
- Latency: data to q[0] is 1 edge. In cascade mode, data to q[k] is at least k+1 edges.

Decomposition:
- Shared package tff_pkg holds the mode constants: MODE_CASCADE=2'b00, MODE_COUNT=2'b01, MODE_HOLD=2'b10, MODE_LOAD=2'b11.
- Sub-module tff_cell: one T flip-flop with async active-high reset, sync clear, load, load bit and toggle-enable inputs.
  - Instantiated STAGES times via generate.
  - The top computes the per-stage toggle enables, tc and q_rise.

Test Plan (STAGES=4; q shown as q3..q0):
1. Async reset: count to q=0110, then pulse rst between edges -> q=0000, tc=0, q_rise=0 immediately, before the next edge. After release, counting resumes from 0000.
2. Count mode: data=1 held for 16 edges from 0000 -> q steps 0001..1111,0000. tc=1 only in the cycle q=0000 after the wrap. q_rise=1 in the cycle after q becomes 1000.
3. Cascade mode: reset, then data=1 for one edge, then 0 -> after edge1 q=0001, edge2 0011, edge3 0101, edge4 1111. q_rise=1 in the cycle after edge4. tc stays 0.
4. Load/hold: mode=11, load_val=1010 -> q=1010 after one edge, q_rise=1 next cycle. Then mode=10 with data=1 for 3 edges -> q stays 1010.
5. Simultaneous events: q=1111, mode=01, data=1, clr=1 -> q=0000, tc=0. Separately, clr=1 with mode=11, load_val=0101 -> q=0000.
6. Count mode gating: q=0011 with data alternating 1,0,1 -> q=0100, 0100, 0101.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared mode encoding for the T flip-flop chain family.
package tff_pkg;

  typedef enum logic [1:0] {
    MODE_CASCADE = 2'b00,
    MODE_COUNT   = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_LOAD    = 2'b11
  } mode_e;

endpackage

// File: rtl/tff_cell.sv
// One T flip-flop stage: async reset, then sync clear > load > toggle.
// Also exposes its next-state value so the parent can detect edges without re-deriving it.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic load_bit,
  input  logic toggle,
  output logic q,
  output logic nxt
);

  always_comb begin
    if (clr)       nxt = 1'b0;
    else if (load) nxt = load_bit;
    else           nxt = q ^ toggle;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= nxt;
  end

endmodule

// File: rtl/tff_chain_n.sv
// Parametrised T flip-flop chain: cascade or binary-count toggling, hold, load,
// sync clear, terminal-count pulse and last-stage rising-edge pulse.
module tff_chain_n
  import tff_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data,
  input  logic [1:0]        mode,
  input  logic              clr,
  input  logic [STAGES-1:0] load_val,
  output logic [STAGES-1:0] q,
  output logic              q_last,
  output logic              tc,
  output logic              q_rise
);

  logic [STAGES-1:0] toggle;
  logic [STAGES-1:0] nxt;
  logic              load;
  logic              carry;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    toggle = '0;
    load   = 1'b0;
    carry  = data;
    unique case (mode_e'(mode))
      MODE_CASCADE: begin
        toggle[0] = data;
        for (int i = 1; i < STAGES; i++) toggle[i] = q[i-1];
      end
      MODE_COUNT: begin
        // Carry chain: stage i toggles when data and all lower stages are high.
        for (int i = 0; i < STAGES; i++) begin
          toggle[i] = carry;
          carry     = carry & q[i];
        end
      end
      MODE_HOLD: ;
      MODE_LOAD: load = 1'b1;
      default: ;
    endcase
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    tff_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .load_bit (load_val[g]),
      .toggle   (toggle[g]),
      .q        (q[g]),
      .nxt      (nxt[g])
    );
  end

  assign q_last = q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc     <= 1'b0;
      q_rise <= 1'b0;
    end else begin
      tc     <= (mode == MODE_COUNT) & data & (&q) & ~clr;
      q_rise <= nxt[STAGES-1] & ~q[STAGES-1];
    end
  end

endmodule

// File: tb/tb_tff_chain_n.sv
// Randomised scoreboard bench for tff_chain_n (STAGES=4) against an arithmetic reference model.
module tb_tff_chain_n;
  import tff_pkg::*;

  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data = 1'b0;
  logic [1:0]   mode = MODE_HOLD;
  logic         clr = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] q;
  logic         q_last;
  logic         tc;
  logic         q_rise;

  tff_chain_n #(.STAGES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .mode     (mode),
    .clr      (clr),
    .load_val (load_val),
    .q        (q),
    .q_last   (q_last),
    .tc       (tc),
    .q_rise   (q_rise)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit tc;
    bit rise;
  } exp_t;

  exp_t sb[$];
  int   q_m = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: counting is integer arithmetic; cascade toggles each bit whose
  // lower neighbour (or data, for bit 0) was high before the edge.
  function automatic exp_t model(input bit d, input int m, input bit c, input int lv);
    exp_t e;
    int   nq;
    if (c)           nq = 0;
    else if (m == 0) nq = q_m ^ (((q_m << 1) | int'(d)) & MASK);
    else if (m == 1) nq = d ? (q_m + 1) % (MASK + 1) : q_m;
    else if (m == 2) nq = q_m;
    else             nq = lv & MASK;
    e.q    = nq;
    e.tc   = (m == 1) && d && (q_m == MASK) && !c;
    e.rise = ((nq >> (N - 1)) & 1) == 1 && ((q_m >> (N - 1)) & 1) == 0;
    q_m    = nq;
    return e;
  endfunction

  task automatic step(input bit d, input int m, input bit c, input int lv);
    @(negedge clk);
    data     = d;
    mode     = m[1:0];
    clr      = c;
    load_val = lv[N-1:0];
    sb.push_back(model(d, m, c, lv));
  endtask

  // Mid-cycle reset pulse, checked immediately, then one hold edge from zero.
  task automatic pulse_rst();
    exp_t e;
    @(negedge clk);
    data = 1'b0;
    mode = MODE_HOLD;
    clr  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_q", int'(q), 0);
    check("async_rst_tc", int'(tc), 0);
    check("async_rst_rise", int'(q_rise), 0);
    #1 rst = 1'b0;
    q_m    = 0;
    e.q    = 0;
    e.tc   = 1'b0;
    e.rise = 1'b0;
    sb.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is compared one step later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q", int'(q), e.q);
        check("q_last", int'(q_last), (e.q >> (N - 1)) & 1);
        check("tc", int'(tc), int'(e.tc));
        check("q_rise", int'(q_rise), int'(e.rise));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_q", int'(q), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_rise", int'(q_rise), 0);
    rst = 1'b0;

    // Async reset in the middle of counting, then resume.
    repeat (6) step(1, MODE_COUNT, 0, 0);
    pulse_rst();
    repeat (2) step(1, MODE_COUNT, 0, 0);

    // Full count wrap from zero.
    pulse_rst();
    repeat (17) step(1, MODE_COUNT, 0, 0);

    // Cascade ripple from a single data pulse.
    pulse_rst();
    step(1, MODE_CASCADE, 0, 0);
    repeat (4) step(0, MODE_CASCADE, 0, 0);

    // Load then hold with data ignored.
    pulse_rst();
    step(0, MODE_LOAD, 0, 4'b1010);
    repeat (3) step(1, MODE_HOLD, 0, 0);

    // Clear beats a wrapping count, and beats load.
    step(0, MODE_LOAD, 0, 4'b1111);
    step(1, MODE_COUNT, 1, 0);
    step(0, MODE_LOAD, 1, 4'b0101);

    // Count gating by data.
    step(0, MODE_LOAD, 0, 4'b0011);
    step(1, MODE_COUNT, 0, 0);
    step(0, MODE_COUNT, 0, 0);
    step(1, MODE_COUNT, 0, 0);

    // Randomised traffic with occasional clear and reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_rst();
      else step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0, int'($urandom_range(0, MASK)));
    end

    @(negedge clk);
    mode = MODE_HOLD;
    data = 1'b0;
    clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
